// File: rtl/and_operand_join.sv
// and_operand_join: operand stage in front of and1.
// Two independent valid/ready streams (A and B) each feed a small circular
// FIFO. Heads are joined in arrival order into one registered pair
// (out_a/out_b) that drives and1's a/b ports directly. pair_count counts
// delivered pairs.
// Optional build macro AND_JOIN_PARITY_EN adds out_par = ^(out_a & out_b).
// That is the expected parity of and1's c for the presented pair. It is
// registered together with the pair.

// Circular-buffer FIFO. Each pointer carries one extra MSB so that a full
// FIFO and an empty FIFO have different pointer patterns.
module and_join_fifo #(
  parameter int G_WIDTH = 8,
  parameter int G_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [G_WIDTH-1:0] wr_data_i,
  input  logic               wr_valid_i,
  output logic               wr_ready_o,
  input  logic               rd_pop_i,
  output logic [G_WIDTH-1:0] rd_data_o,
  output logic               empty_o
);

  localparam int AW = $clog2(G_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]        wr_ptr_q;
  logic [AW:0]        wr_ptr_d;
  logic [AW:0]        rd_ptr_q;
  logic [AW:0]        rd_ptr_d;
  logic [G_WIDTH-1:0] mem_q [G_DEPTH];
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // Ready depends only on reset and the full flag. It never depends on valid.
  // A full FIFO refuses a write even when it is popped on the same edge.
  assign wr_ready_o = rst_n & ~full;
  assign push       = wr_valid_i & wr_ready_o;
  assign pop        = rd_pop_i & ~empty;

  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o   = empty;

  // Next pointer values. The pointers wrap naturally modulo 2*G_DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Pointer registers. Reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array. Its contents are meaningless until written, so it has no
  // reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

endmodule

// Top level: two operand FIFOs, the join/output register and the pair counter.
module and_operand_join #(
  parameter int G_WIDTH = 8,
  parameter int G_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [G_WIDTH-1:0] a_data,
  input  logic               a_valid,
  output logic               a_ready,
  input  logic [G_WIDTH-1:0] b_data,
  input  logic               b_valid,
  output logic               b_ready,
  output logic [G_WIDTH-1:0] out_a,
  output logic [G_WIDTH-1:0] out_b,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef AND_JOIN_PARITY_EN
  output logic               out_par,
`endif
  output logic [15:0]        pair_count
);

  logic [G_WIDTH-1:0] a_head;
  logic [G_WIDTH-1:0] b_head;
  logic               a_empty;
  logic               b_empty;
  logic               load;
  logic               xfer;

  logic [G_WIDTH-1:0] out_a_q;
  logic [G_WIDTH-1:0] out_a_d;
  logic [G_WIDTH-1:0] out_b_q;
  logic [G_WIDTH-1:0] out_b_d;
  logic               out_valid_q;
  logic               out_valid_d;
  logic [15:0]        pair_count_q;
  logic [15:0]        pair_count_d;

  and_join_fifo #(
    .G_WIDTH (G_WIDTH),
    .G_DEPTH (G_DEPTH)
  ) u_fifo_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_data_i  (a_data),
    .wr_valid_i (a_valid),
    .wr_ready_o (a_ready),
    .rd_pop_i   (load),
    .rd_data_o  (a_head),
    .empty_o    (a_empty)
  );

  and_join_fifo #(
    .G_WIDTH (G_WIDTH),
    .G_DEPTH (G_DEPTH)
  ) u_fifo_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_data_i  (b_data),
    .wr_valid_i (b_valid),
    .wr_ready_o (b_ready),
    .rd_pop_i   (load),
    .rd_data_o  (b_head),
    .empty_o    (b_empty)
  );

  // A pair is loaded only when both heads are present and the output
  // register is free or is being emptied on this edge.
  assign load = ~a_empty & ~b_empty & (~out_valid_q | out_ready);
  assign xfer = out_valid_q & out_ready;

  // Next state of the output register and the pair counter.
  always_comb begin
    out_a_d      = out_a_q;
    out_b_d      = out_b_q;
    out_valid_d  = out_valid_q;
    pair_count_d = pair_count_q;
    if (load) begin
      out_a_d     = a_head;
      out_b_d     = b_head;
      out_valid_d = 1'b1;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
    if (xfer) begin
      pair_count_d = pair_count_q + 16'd1;
    end
  end

  // Output and counter registers. A mid-stream reset drops the presented pair.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_a_q      <= '0;
      out_b_q      <= '0;
      out_valid_q  <= 1'b0;
      pair_count_q <= '0;
    end else begin
      out_a_q      <= out_a_d;
      out_b_q      <= out_b_d;
      out_valid_q  <= out_valid_d;
      pair_count_q <= pair_count_d;
    end
  end

  assign out_a      = out_a_q;
  assign out_b      = out_b_q;
  assign out_valid  = out_valid_q;
  assign pair_count = pair_count_q;

`ifdef AND_JOIN_PARITY_EN
  logic out_par_q;
  logic out_par_d;

  // The parity bit is computed from the FIFO heads, so it is loaded in step
  // with the pair it describes.
  always_comb begin
    out_par_d = out_par_q;
    if (load) begin
      out_par_d = ^(a_head & b_head);
    end
  end

  // Parity register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_par_q <= 1'b0;
    end else begin
      out_par_q <= out_par_d;
    end
  end

  assign out_par = out_par_q;
`endif

endmodule

// File: tb/tb_and_operand_join.sv
// Bench for and_operand_join: table-driven pairs, directed corner sequences
// and a scoreboard that pairs accepted A/B beats and checks delivered pairs.
module tb_and_operand_join;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  a_data;
  logic        a_valid;
  logic        a_ready;
  logic [7:0]  b_data;
  logic        b_valid;
  logic        b_ready;
  logic [7:0]  out_a;
  logic [7:0]  out_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] pair_count;
`ifdef AND_JOIN_PARITY_EN
  logic        out_par;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  a_q[$];
  logic [7:0]  b_q[$];
  logic [15:0] exp_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  and_operand_join #(.G_WIDTH(8), .G_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_data     (a_data),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .b_data     (b_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef AND_JOIN_PARITY_EN
    .out_par    (out_par),
`endif
    .pair_count (pair_count)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Runs once per cycle, on the falling edge, ahead of the rising edge that
  // performs the handshakes.
  task automatic monitor_step();
    logic [15:0] e;
    if (rst_n !== 1'b1) begin
      a_q.delete();
      b_q.delete();
      exp_q.delete();
    end else begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        check("pair_avail", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("pair_data", {out_a, out_b}, e);
        end
      end
      if (a_valid === 1'b1 && a_ready === 1'b1) a_q.push_back(a_data);
      if (b_valid === 1'b1 && b_ready === 1'b1) b_q.push_back(b_data);
      while (a_q.size() != 0 && b_q.size() != 0) begin
        exp_q.push_back({a_q.pop_front(), b_q.pop_front()});
      end
    end
  endtask

  // Drivers are entered 1 time unit after a rising edge.
  task automatic send_a(input logic [7:0] v);
    bit ok = 1'b0;
    int n = 0;
    a_data  = v;
    a_valid = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = (a_ready === 1'b1);
      @(posedge clk);
      #1;
      n++;
    end
    a_valid = 1'b0;
    check("a_accept", ok, 1);
  endtask

  task automatic send_b(input logic [7:0] v);
    bit ok = 1'b0;
    int n = 0;
    b_data  = v;
    b_valid = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = (b_ready === 1'b1);
      @(posedge clk);
      #1;
      n++;
    end
    b_valid = 1'b0;
    check("b_accept", ok, 1);
  endtask

  task automatic push_pair(input logic [7:0] va, input logic [7:0] vb);
    fork
      send_a(va);
      send_b(vb);
    join
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(nm, out_valid, 1);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    @(negedge clk);
    while ((out_valid !== 1'b0 || exp_q.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(nm, out_valid, 0);
  endtask

  task automatic reset_dut();
    rst_n   = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    rst_n     = 1'b0;
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    a_data    = 8'h00;
    b_data    = 8'h00;
    out_ready = 1'b1;
    vecs[0] = '{a: 8'hF0, b: 8'h3C, c: 8'h30};
    vecs[1] = '{a: 8'hFF, b: 8'h00, c: 8'h00};
    vecs[2] = '{a: 8'hAA, b: 8'h55, c: 8'h00};
    vecs[3] = '{a: 8'hA5, b: 8'hF0, c: 8'hA0};
    vecs[4] = '{a: 8'h0F, b: 8'hFF, c: 8'h0F};
    vecs[5] = '{a: 8'hC3, b: 8'h81, c: 8'h81};

    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    // Reset state, then one pair with its latency.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_a", out_a, 0);
    check("rst_out_b", out_b, 0);
    check("rst_count", pair_count, 0);
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    a_data  = 8'hF0;
    a_valid = 1'b1;
    b_data  = 8'h3C;
    b_valid = 1'b1;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(negedge clk);
    check("t1_valid_e1", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check("t1_valid_e2", out_valid, 1);
    check("t1_out_a", out_a, 8'hF0);
    check("t1_out_b", out_b, 8'h3C);
    check("t1_c", out_a & out_b, 8'h30);
    @(posedge clk);
    @(negedge clk);
    check("t1_count", pair_count, 1);
    check("t1_valid_e3", out_valid, 0);

    // Table of single pairs.
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      push_pair(vecs[i].a, vecs[i].b);
      wait_valid("tbl_valid");
      check("tbl_c", out_a & out_b, vecs[i].c);
`ifdef AND_JOIN_PARITY_EN
      check("tbl_par", out_par, ^vecs[i].c);
`endif
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("tbl_count", pair_count, 7);

    // A stream runs four beats ahead and fills its FIFO.
    @(posedge clk);
    #1;
    send_a(8'h01);
    send_a(8'h02);
    send_a(8'h03);
    send_a(8'h04);
    @(negedge clk);
    check("skew_a_full", a_ready, 0);
    check("skew_no_out", out_valid, 0);
    @(posedge clk);
    #1;
    b_data  = 8'h10;
    b_valid = 1'b1;
    @(posedge clk);
    #1;
    b_data = 8'h20;
    @(negedge clk);
    check("skew_a_still_full", a_ready, 0);
    check("skew_no_out2", out_valid, 0);
    @(posedge clk);
    #1;
    b_data = 8'h30;
    @(negedge clk);
    check("skew_a_ready_back", a_ready, 1);
    check("skew_first_valid", out_valid, 1);
    check("skew_first_pair", {out_a, out_b}, 16'h0110);
    @(posedge clk);
    #1;
    b_data = 8'h40;
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    wait_idle("skew_drain");
    check("skew_count", pair_count, 11);

    // Backpressure holds the presented pair stable.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    push_pair(8'hAA, 8'h55);
    push_pair(8'h11, 8'h22);
    wait_valid("bp_valid");
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_pair", {out_a, out_b}, 16'hAA55);
      check("bp_hold_count", pair_count, 11);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_next_valid", out_valid, 1);
    check("bp_next_pair", {out_a, out_b}, 16'h1122);
    check("bp_count", pair_count, 12);
    @(posedge clk);
    @(negedge clk);
    check("bp_count2", pair_count, 13);

    // Back-to-back random pairs, counted from a fresh reset.
    @(posedge clk);
    #1;
    reset_dut();
    @(negedge clk);
    check("st_count0", pair_count, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 50; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      push_pair(ra, rb);
    end
    @(posedge clk);
    @(negedge clk);
    check("st_last_valid", out_valid, 1);
    check("st_count49", pair_count, 49);
    @(posedge clk);
    @(negedge clk);
    check("st_count50", pair_count, 50);
    check("st_idle", out_valid, 0);

    // Reset while data is buffered and a pair is presented.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    push_pair(8'h11, 8'h22);
    wait_valid("mr_valid");
    @(posedge clk);
    #1;
    send_a(8'h33);
    send_a(8'h44);
    send_a(8'h55);
    send_b(8'h66);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mr_out_valid", out_valid, 0);
    check("mr_count", pair_count, 0);
    check("mr_out_a", out_a, 0);
    check("mr_a_ready", a_ready, 1);
    check("mr_b_ready", b_ready, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mr_no_stale", out_valid, 0);
    @(posedge clk);
    #1;
    push_pair(8'hFF, 8'h0F);
    wait_valid("mr_fresh_valid");
    check("mr_fresh_pair", {out_a, out_b}, 16'hFF0F);
    check("mr_fresh_count", pair_count, 0);
    @(posedge clk);
    #1;

    // Counter wrap over 65537 pairs.
    reset_dut();
    for (int i = 0; i < 65537; i++) begin
      ra = i[7:0];
      push_pair(ra, ~ra);
    end
    @(posedge clk);
    @(negedge clk);
    check("wrap_zero", pair_count, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    check("wrap_one", pair_count, 16'h0001);

`ifdef AND_JOIN_PARITY_EN
    @(posedge clk);
    #1;
    push_pair(8'h07, 8'h03);
    wait_valid("par0_valid");
    check("par0", out_par, 0);
    @(posedge clk);
    #1;
    push_pair(8'h07, 8'h01);
    wait_valid("par1_valid");
    check("par1", out_par, 1);
`endif

    @(posedge clk);
    #1;
    wait_idle("final_idle");
    @(posedge clk);
    #1;
    check("sb_leftover", exp_q.size() + a_q.size() + b_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/and_operand_join.md
Name: and_operand_join

Overview:
- Upstream operand stage for and1.
- Accepts operand A and operand B on two independent valid/ready streams and buffers each stream in its own FIFO.
- Joins them in arrival order into aligned pairs. Presents each pair as registered out_a/out_b, which drive and1's a/b ports directly.
- Counts delivered pairs so the bench can match results to stimulus.

Parameters:
- G_WIDTH, 8, operand width in bits; must equal and1 G_WIDTH.
- G_DEPTH, 4, entries per input FIFO; power of 2, minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- a_data  in  G_WIDTH  operand A payload.
- a_valid  in  1  operand A valid.
- a_ready  out  1  operand A FIFO can accept.
- b_data  in  G_WIDTH  operand B payload.
- b_valid  in  1  operand B valid.
- b_ready  out  1  operand B FIFO can accept.
- out_a  out  G_WIDTH  paired operand A, to and1 a.
- out_b  out  G_WIDTH  paired operand B, to and1 b.
- out_valid  out  1  pair present.
- out_ready  in  1  consumer takes pair.
- pair_count  out  16  pairs delivered since reset.

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n), sampled on the rising edge of clk.
- Reset state while rst_n=0 at an edge:
  - Both FIFOs emptied; read and write pointers set to 0.
  - out_valid=0, out_a=0, out_b=0, pair_count=0.
  - a_ready and b_ready are forced 0 while rst_n=0.
- Reset mid-operation discards all buffered and presented data. Nothing is delivered after the reset edge.
- Input acceptance:
  - A beat is accepted on an edge where a_valid&a_ready (or b_valid&b_ready).
  - a_ready = rst_n & !a_full; b_ready likewise. Both are combinational from FIFO state only, never from valid.
  - A and B are fully independent: either stream may run up to G_DEPTH beats ahead of the other.
- FIFO:
  - Circular buffer with pointer width log2(G_DEPTH)+1. The extra MSB distinguishes full from empty.
  - Full when the pointer LSBs match and the MSBs differ. Empty when the pointers are equal.
  - Pointers wrap naturally modulo 2*G_DEPTH.
  - No write-through when full: a full FIFO accepts nothing that cycle, even if it is popped on the same edge.
  - Simultaneous push and pop on a non-full, non-empty FIFO keeps occupancy unchanged.
- Join / output register:
  - load = !a_empty & !b_empty & (!out_valid | out_ready).
  - On load: out_a <= A head, out_b <= B head, both FIFOs popped, out_valid <= 1.
  - On out_valid&out_ready with no load: out_valid <= 0. out_a/out_b hold their last values.
  - While out_valid=1 and out_ready=0, out_a/out_b/out_valid are held stable.
- Latency: a pair whose later operand is accepted at edge k appears with out_valid=1 after edge k+1, provided the output register is free. Full throughput is 1 pair/clk with out_ready held high.
- pair_count:
  - Increments by 1 on each edge with out_valid&out_ready.
  - Wraps 0xFFFF -> 0x0000 with no flag.
- Ordering: pairs are strictly FIFO-ordered per stream. The Nth A is always paired with the Nth B.

Optional Feature:
- Macro: AND_JOIN_PARITY_EN.
- When defined:
  - Adds output port out_par (1 bit) = ^(out_a & out_b).
  - out_par is registered on load together with out_a/out_b, so it is the expected parity of and1's c for the presented pair.
  - Reset value is 0.
- When not defined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
1. Reset then single pair:
   - Stimulus: after reset release, a_data=0xF0 at edge 1, b_data=0x3C at edge 1; out_ready=1.
   - Response: out_valid=1 after edge 2 with out_a=0xF0, out_b=0x3C; and1 c=0x30; pair_count=1 after edge 3.
2. Skewed streams:
   - Stimulus: push A=0x01,0x02,0x03,0x04 with b_valid=0.
   - Response: a_ready=0 after the 4th push and out_valid stays 0.
   - Stimulus: then push B=0x10,0x20,0x30,0x40.
   - Response: pairs (01,10),(02,20),(03,30),(04,40) emerge in order; a_ready returns to 1 the cycle after the first load.
3. Backpressure:
   - Stimulus: out_ready=0 with pair (0xAA,0x55) presented for 5 clocks.
   - Response: outputs are stable for all 5 clocks; pair_count is unchanged.
   - Stimulus: then out_ready=1.
   - Response: next pair follows on the next clock; count advances by 1.
4. Streaming throughput:
   - Stimulus: 50 random pairs with both valids and out_ready tied high.
   - Response: one pair per clock after the initial latency; every and1 c == out_a&out_b; pair_count=50.
5. Reset mid-operation:
   - Stimulus: 3 A and 1 B buffered plus 1 pair presented, then assert rst_n=0 for 1 edge.
   - Response: out_valid=0, pair_count=0, FIFOs empty. A fresh pair (0xFF,0x0F) then yields out_a=0xFF, out_b=0x0F as the first output.
6. Counter wrap and parity option:
   - Stimulus: with AND_JOIN_PARITY_EN defined, deliver 65537 pairs.
   - Response: pair_count reads 0x0001; pair (0x07,0x03) gives out_par=0 and (0x07,0x01) gives out_par=1.
